clock_period_meter: RTL and testbench

//   Receive end of the divided sample clock: measures a slow clock/strobe
//   (e.g. the ~5.3 kHz sine sample clock) in clk_in cycles. Reports period
//   and high time, flags loss of signal, and asserts lock once the period is stable.

---
 rtl/clock_period_meter.sv | 166 ++++++++++++++++
 tb/tb_clock_period_meter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | clock_period_meter: measures period/high time of a slow strobe in      |
// | clk_in cycles, with lock and loss-of-signal flags. Rev 1.0             |
// +------------------------------------------------------------------------+
module clock_period_meter #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 65535,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   TOL_V      = (CNT_W+1)'(TOL);
  localparam logic [3:0]       LOCK_V     = 4'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic             have_prev_q, have_prev_d;

  logic             rise, fall;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W:0]   new_ext, prev_ext, abs_diff;
  logic [3:0]       match_next;

  assign rise      = s2_q & ~s3_q;
  assign fall      = ~s2_q & s3_q;
  assign count_inc = count_q + CNT_W'(1);

  // One extra bit so the distance between periods never wraps.
  assign new_ext  = {1'b0, count_inc};
  assign prev_ext = {1'b0, period_q};
  assign abs_diff = (new_ext >= prev_ext) ? (new_ext - prev_ext) : (prev_ext - new_ext);

  assign match_next = (match_cnt_q >= LOCK_V) ? match_cnt_q : (match_cnt_q + 4'd1);

  always_comb begin
    state_d        = state_q;
    s1_d           = sig_in;
    s2_d           = s1_q;
    s3_d           = s2_q;
    hi_cap_d       = hi_cap_q;
    period_d       = period_q;
    high_time_d    = high_time_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    timeout_d      = timeout_q;
    match_cnt_d    = match_cnt_q;
    have_prev_d    = have_prev_q;

    if (rise) begin
      count_d = '0;
    end else if (count_q == TIMEOUT_V) begin
      count_d = count_q;
    end else begin
      count_d = count_inc;
    end

    case (state_q)
      IDLE: begin
        locked_d = 1'b0;
        if (rise) begin
          state_d     = MEAS;
          timeout_d   = 1'b0;
          have_prev_d = 1'b0;
          match_cnt_d = '0;
        end
      end
      MEAS: begin
        if (fall) begin
          hi_cap_d = count_inc;
        end
        // A rise on the last allowed cycle still counts as a valid period.
        if (rise) begin
          period_d       = count_inc;
          high_time_d    = hi_cap_q;
          period_valid_d = 1'b1;
          have_prev_d    = 1'b1;
          if (have_prev_q) begin
            if (abs_diff <= TOL_V) begin
              match_cnt_d = match_next;
              if (match_next == LOCK_V) begin
                locked_d = 1'b1;
              end
            end else begin
              match_cnt_d = '0;
              locked_d    = 1'b0;
            end
          end
        end else if (count_q == TIMEOUT_M1) begin
          timeout_d   = 1'b1;
          locked_d    = 1'b0;
          match_cnt_d = '0;
          have_prev_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      count_q        <= '0;
      hi_cap_q       <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
      match_cnt_q    <= '0;
      have_prev_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      count_q        <= count_d;
      hi_cap_q       <= hi_cap_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      timeout_q      <= timeout_d;
      match_cnt_q    <= match_cnt_d;
      have_prev_q    <= have_prev_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_time_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_period_meter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_clock_period_meter: scoreboard bench for clock_period_meter.        |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_clock_period_meter;

  localparam int CNT_W      = 16;
  localparam int TIMEOUT    = 10000;
  localparam int LOCK_COUNT = 4;
  localparam int TOL        = 2;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b1;
  logic             sig_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             timeout;

  clock_period_meter #(
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .LOCK_COUNT(LOCK_COUNT),
    .TOL       (TOL)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sig_in      (sig_in),
    .period      (period),
    .high_time   (high_time),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int p;
    int h;
    bit lk;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  bit armed, have_prev, exp_lk, saw_timeout, prev_valid;
  int pend_p, pend_h, prev_p, mcnt, last_p, last_h, rise_cyc, valid_count;

  // Output side of the scoreboard.
  always @(negedge clk_in) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (timeout) saw_timeout = 1'b1;
      if (period_valid) begin
        valid_count++;
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL valid_width: period_valid=1 on consecutive cycles, required one-cycle pulse");
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: period_valid=1 period=%0d high_time=%0d, required no pulse", period, high_time);
        end else begin
          e = sb.pop_front();
          checks++;
          if (period !== CNT_W'(e.p)) begin
            errors++;
            $display("FAIL period: got %0d, expected %0d", period, e.p);
          end
          checks++;
          if (high_time !== CNT_W'(e.h)) begin
            errors++;
            $display("FAIL high_time: got %0d, expected %0d", high_time, e.h);
          end
          checks++;
          if (locked !== e.lk) begin
            errors++;
            $display("FAIL locked_at_valid: got %b, expected %b (period %0d)", locked, e.lk, e.p);
          end
        end
      end
      prev_valid = period_valid;
    end
  end

  task automatic hold(input logic lvl, input int n);
    sig_in = lvl;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    armed     = 1'b0;
    have_prev = 1'b0;
    mcnt      = 0;
    exp_lk    = 1'b0;
  endtask

  // Drive a rising edge; if a period was in progress it completes here.
  task automatic edge_rise();
    int d;
    if (armed) begin
      if (have_prev) begin
        d = pend_p - prev_p;
        if (d < 0) d = -d;
        if (d <= TOL) begin
          if (mcnt < LOCK_COUNT) mcnt++;
          if (mcnt == LOCK_COUNT) exp_lk = 1'b1;
        end else begin
          mcnt   = 0;
          exp_lk = 1'b0;
        end
      end
      have_prev = 1'b1;
      prev_p    = pend_p;
      last_p    = pend_p;
      last_h    = pend_h;
      sb.push_back('{pend_p, pend_h, exp_lk});
    end
    armed    = 1'b1;
    rise_cyc = cyc;
    sig_in   = 1'b1;
  endtask

  task automatic wave(input int h, input int p);
    edge_rise();
    pend_p = p;
    pend_h = h;
    hold(1'b1, h);
    hold(1'b0, p - h);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d results still pending, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    checks++; if (period !== '0)       begin errors++; $display("FAIL reset_period: got %0d, expected 0", period); end
    checks++; if (high_time !== '0)    begin errors++; $display("FAIL reset_high_time: got %0d, expected 0", high_time); end
    checks++; if (period_valid !== 0)  begin errors++; $display("FAIL reset_valid: got %b, expected 0", period_valid); end
    checks++; if (locked !== 0)        begin errors++; $display("FAIL reset_locked: got %b, expected 0", locked); end
    checks++; if (timeout !== 0)       begin errors++; $display("FAIL reset_timeout: got %b, expected 0", timeout); end
    rst = 1'b0;
    model_reset();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_period_lock();
    repeat (6) wave(4688, 9376);
    drain("period_lock");
    checks++; if (period !== 16'd9376)   begin errors++; $display("FAIL lock_period: got %0d, expected 9376", period); end
    checks++; if (high_time !== 16'd4688) begin errors++; $display("FAIL lock_high_time: got %0d, expected 4688", high_time); end
    checks++; if (locked !== 1'b1)        begin errors++; $display("FAIL lock_asserted: got %b, expected 1", locked); end
  endtask

  // Scaled-down periods keep the run short; tolerance behaviour is the same.
  task automatic test_lock_tolerance();
    int seq[15] = '{200, 200, 200, 200, 200, 200, 202, 200, 198, 204, 204, 204, 204, 204, 204};
    foreach (seq[i]) wave(seq[i] / 2, seq[i]);
    drain("tolerance");
    checks++; if (period !== 16'd204) begin errors++; $display("FAIL tol_period: got %0d, expected 204", period); end
    checks++; if (locked !== 1'b1)    begin errors++; $display("FAIL tol_relock: got %b, expected 1", locked); end
  endtask

  task automatic test_timeout();
    int n = 0;
    while (timeout !== 1'b1 && n < TIMEOUT + 50) begin
      @(negedge clk_in);
      n++;
    end
    checks++;
    if (timeout !== 1'b1 || cyc !== rise_cyc + TIMEOUT + 3) begin
      errors++;
      $display("FAIL timeout_time: timeout=%b at cycle %0d, expected 1 at cycle %0d", timeout, cyc, rise_cyc + TIMEOUT + 3);
    end
    checks++; if (locked !== 1'b0)             begin errors++; $display("FAIL timeout_locked: got %b, expected 0", locked); end
    checks++; if (period !== CNT_W'(last_p))   begin errors++; $display("FAIL timeout_period_hold: got %0d, expected %0d", period, last_p); end
    checks++; if (high_time !== CNT_W'(last_h)) begin errors++; $display("FAIL timeout_high_hold: got %0d, expected %0d", high_time, last_h); end
    model_reset();
    edge_rise();
    pend_p = TIMEOUT;
    pend_h = 50;
    hold(1'b1, 6);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b, expected 0", timeout); end
    saw_timeout = 1'b0;
    hold(1'b1, 44);
    hold(1'b0, TIMEOUT - 50);
  endtask

  task automatic test_timeout_boundary();
    wave(2, 5);
    drain("boundary");
    checks++; if (saw_timeout !== 1'b0)         begin errors++; $display("FAIL boundary_no_timeout: timeout seen=%b, expected 0", saw_timeout); end
    checks++; if (period !== CNT_W'(TIMEOUT))  begin errors++; $display("FAIL boundary_period: got %0d, expected %0d", period, TIMEOUT); end
  endtask

  task automatic test_min_period();
    repeat (8) wave(1, 2);
    wave(2, 6);
    drain("min_period");
    checks++; if (period !== 16'd2)    begin errors++; $display("FAIL min_period: got %0d, expected 2", period); end
    checks++; if (high_time !== 16'd1) begin errors++; $display("FAIL min_high_time: got %0d, expected 1", high_time); end
    checks++; if (locked !== 1'b1)     begin errors++; $display("FAIL min_locked: got %b, expected 1", locked); end
  endtask

  task automatic test_reset_mid();
    int vc;
    edge_rise();
    hold(1'b1, 5);
    #2 rst = 1'b1;
    #1;
    checks++; if (period !== '0)      begin errors++; $display("FAIL mid_reset_period: got %0d, expected 0", period); end
    checks++; if (high_time !== '0)   begin errors++; $display("FAIL mid_reset_high: got %0d, expected 0", high_time); end
    checks++; if (period_valid !== 0) begin errors++; $display("FAIL mid_reset_valid: got %b, expected 0", period_valid); end
    checks++; if (locked !== 0)       begin errors++; $display("FAIL mid_reset_locked: got %b, expected 0", locked); end
    checks++; if (timeout !== 0)      begin errors++; $display("FAIL mid_reset_timeout: got %b, expected 0", timeout); end
    sb.delete();
    model_reset();
    hold(1'b0, 3);
    hold(1'b1, 3);
    hold(1'b0, 3);
    @(negedge clk_in);
    rst = 1'b0;
    hold(1'b0, 3);
    vc = valid_count;
    wave(3, 8);
    checks++; if (valid_count !== vc) begin errors++; $display("FAIL first_rise_valid: %0d pulses, expected 0", valid_count - vc); end
    wave(3, 8);
    drain("reset_mid");
    checks++; if (period !== 16'd8) begin errors++; $display("FAIL post_reset_period: got %0d, expected 8", period); end
  endtask

  initial begin
    model_reset();
    valid_count = 0;
    saw_timeout = 1'b0;
    test_reset();
    test_period_lock();
    test_lock_tolerance();
    test_timeout();
    test_timeout_boundary();
    test_min_period();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
